// File: rtl/mul12_rr_sched.sv
// Round-robin scheduler sharing one registered 12x12 multiplier between N requesters.
// Define MUL_COMP_EN to add a saturating COMP_CONST bias to each product.
module mul12_rr_sched #(
  parameter int          N          = 4,
  parameter int          IDW        = 2,
  parameter logic [23:0] COMP_CONST = 24'h05F800
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*12-1:0] req_a,
  input  logic [N*12-1:0] req_b,
  output logic [11:0]     mul_a,
  output logic [11:0]     mul_b,
  input  logic [23:0]     mul_o,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [23:0]     res_data,
  output logic [IDW-1:0]  res_id,
  output logic            busy
);

  localparam int PW = IDW + 1;

`ifdef MUL_COMP_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif

  logic           s1_v;
  logic [IDW-1:0] s1_id;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] next_ptr;
  logic [PW-1:0]  scan;
  logic           found;
  logic           s2_free;
  logic           s1_adv;
  logic           s1_accept;
  logic           xfer;
  logic [11:0]    sel_a;
  logic [11:0]    sel_b;
  logic [24:0]    comp_sum;
  logic [23:0]    res_next;

  assign s2_free   = !res_valid || res_ready;
  assign s1_adv    = s1_v && s2_free;
  assign s1_accept = !s1_v || s1_adv;
  assign xfer      = s1_accept && found;
  assign busy      = s1_v || res_valid;

  // Scan ptr, ptr+1, ... wrapping at N; the first valid requester wins.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = PW'(ptr) + PW'(k);
      if (scan >= PW'(N)) scan = scan - PW'(N);
      if (!found && req_valid[scan[IDW-1:0]]) begin
        found     = 1'b1;
        grant_idx = scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && xfer) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N; k++) begin
      if (IDW'(k) == grant_idx) begin
        sel_a = req_a[12*k +: 12];
        sel_b = req_b[12*k +: 12];
      end
    end
  end

  assign next_ptr = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);

  // With compensation disabled COMP_EN is constant zero and the adder folds away.
  always_comb begin
    comp_sum = {1'b0, mul_o} + {1'b0, COMP_CONST};
    res_next = mul_o;
    if (COMP_EN) res_next = comp_sum[24] ? 24'hFFFFFF : comp_sum[23:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v  <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      s1_id <= '0;
      ptr   <= '0;
    end else if (xfer) begin
      s1_v  <= 1'b1;
      mul_a <= sel_a;
      mul_b <= sel_b;
      s1_id <= grant_idx;
      ptr   <= next_ptr;
    end else if (s1_adv) begin
      s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (s1_adv) begin
      res_valid <= 1'b1;
      res_data  <= res_next;
      res_id    <= s1_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
